// File: rtl/program_sequencer.sv
// program_sequencer: loads instruction words into a program store, issues them one at a time
// to the datapath and captures each registered datapath result into a result store.
module program_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [ADDR_W-1:0]     load_addr,
   input  logic [3+2*DATA_W-1:0] load_instr,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     last_addr,
   output logic [2:0]            opcode,
   output logic [DATA_W-1:0]     a,
   output logic [DATA_W-1:0]     b,
   output logic                  issue_valid,
   input  logic [DATA_W-1:0]     result_in,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic [ADDR_W-1:0]     pc,
   output logic                  busy,
   output logic                  done
);
   localparam int IW = 3 + 2*DATA_W;
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   logic [1:0]        state;
   logic [ADDR_W-1:0] last;
   logic [ADDR_W-1:0] nxt;
   logic [ADDR_W-1:0] fetch;
   logic [IW-1:0]     word;
   logic [IW-1:0]     prog [DEPTH];
   logic [DATA_W-1:0] res  [DEPTH];
   assign nxt     = pc + 1'b1;
   assign fetch   = (state == IDLE) ? '0 : nxt;
   assign word    = prog[fetch];
   assign rd_data = res[rd_addr];
   // outputs are loaded on the edge entering each state so they are registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= '0;
         last        <= '0;
         {opcode, a, b} <= '0;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         issue_valid <= 1'b0;
         done        <= 1'b0;
         case (state)
            IDLE: if (start && !load_en) begin
               state          <= ISSUE;
               pc             <= '0;
               last           <= last_addr;
               {opcode, a, b} <= word;
               issue_valid    <= 1'b1;
               busy           <= 1'b1;
            end
            ISSUE: state <= WAIT;
            WAIT: if (pc == last) begin
               state          <= DONE;
               {opcode, a, b} <= '0;
               busy           <= 1'b0;
               done           <= 1'b1;
            end else begin
               state          <= ISSUE;
               pc             <= nxt;
               {opcode, a, b} <= word;
               issue_valid    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // stores are deliberately not reset; reset forces IDLE so no result write can occur
   always_ff @(posedge clk) begin
      if (state == IDLE && load_en) prog[load_addr] <= load_instr;
      if (state == WAIT) res[pc] <= result_in;
   end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: table-driven, hand-written and randomized runs against a store-level model.
module tb_program_sequencer;
   logic        clk = 1'b0;
   logic        rst, load_en, start;
   logic [3:0]  load_addr, last_addr, rd_addr, pc;
   logic [18:0] load_instr;
   logic [2:0]  opcode;
   logic [7:0]  a, b, result_in, rd_data;
   logic        issue_valid, busy, done;
   int          checks = 0;
   int          errors = 0;
   logic [18:0] mprog [16];
   logic [7:0]  mres  [16];
   bit          mval  [16];
   typedef struct {
      logic [7:0] a0;
      logic [7:0] astep;
      logic [7:0] b;
      logic [3:0] last;
      int         dc;
      logic [7:0] r0;
      logic [7:0] rl;
   } vec_t;
   vec_t vt [4];

   program_sequencer dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_instr(load_instr),
      .start(start), .last_addr(last_addr), .opcode(opcode), .a(a), .b(b),
      .issue_valid(issue_valid), .result_in(result_in), .rd_addr(rd_addr), .rd_data(rd_data),
      .pc(pc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always_ff @(posedge clk) result_in <= a + b;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic load_word(input logic [3:0] ad, input logic [18:0] w);
      load_en = 1'b1; load_addr = ad; load_instr = w;
      @(posedge clk); #1;
      load_en = 1'b0;
      mprog[ad] = w;
   endtask

   task automatic check_store();
      for (int i = 0; i < 16; i++)
         if (mval[i]) begin
            rd_addr = 4'(i); #1;
            chk("rd_data", 32'(rd_data), 32'(mres[i]));
         end
   endtask

   task automatic check_idle_zero(input string nm);
      chk({nm, "_pc"}, 32'(pc), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_done"}, 32'(done), 32'd0);
      chk({nm, "_issue"}, 32'(issue_valid), 32'd0);
      chk({nm, "_instr"}, 32'({opcode, a, b}), 32'd0);
   endtask

   // cycle k counts edges from the accepting start edge; odd cycles issue, done at cycle dc
   task automatic run_check(input logic [3:0] l, input int dc, input bit noise);
      last_addr = l; start = 1'b1;
      for (int k = 1; k <= dc + 1; k++) begin
         @(posedge clk); #1;
         chk("issue_valid", 32'(issue_valid), 32'(k < dc && k % 2 == 1));
         chk("busy", 32'(busy), 32'(k < dc));
         chk("done", 32'(done), 32'(k == dc));
         if (k < dc) chk("pc", 32'(pc), 32'((k - 1) / 2));
         if (k < dc && k % 2 == 1) chk("instr", 32'({opcode, a, b}), 32'(mprog[(k - 1) / 2]));
         if (k == dc) begin
            chk("pc_final", 32'(pc), 32'(l));
            chk("cleared", 32'({opcode, a, b}), 32'd0);
         end
         if (noise && k <= dc) begin
            start = 1'($urandom); load_en = 1'($urandom); load_addr = 4'($urandom);
            load_instr = 19'($urandom); last_addr = 4'($urandom);
         end else begin
            start = 1'b0; load_en = 1'b0;
         end
      end
      for (int i = 0; i <= int'(l); i++) begin
         mres[i] = 8'(mprog[i][15:8] + mprog[i][7:0]);
         mval[i] = 1'b1;
      end
      check_store();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{8'h05, 8'h00, 8'h03, 4'd0, 3, 8'h08, 8'h08};
      vt[1] = '{8'h00, 8'h01, 8'h10, 4'd3, 9, 8'h10, 8'h13};
      vt[2] = '{8'hFF, 8'h00, 8'h01, 4'd15, 33, 8'h00, 8'h00};
      vt[3] = '{8'h20, 8'h02, 8'h30, 4'd7, 17, 8'h50, 8'h5E};
      for (int i = 0; i < 16; i++) mval[i] = 1'b0;
      rst = 1'b1; load_en = 1'b0; start = 1'b0; load_addr = '0; load_instr = '0;
      last_addr = '0; rd_addr = '0;
      #2 rst = 1'b0;
      #1 check_idle_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i <= int'(vt[t].last); i++)
            load_word(4'(i), {3'(i), 8'(vt[t].a0 + 8'(i) * vt[t].astep), vt[t].b});
         run_check(vt[t].last, vt[t].dc, 1'b0);
         rd_addr = 4'd0; #1;
         chk("vec_r0", 32'(rd_data), 32'(vt[t].r0));
         rd_addr = vt[t].last; #1;
         chk("vec_rlast", 32'(rd_data), 32'(vt[t].rl));
      end
      // load and start together: load wins, no run starts
      load_en = 1'b1; load_addr = 4'd0; load_instr = {3'd5, 8'h41, 8'h22};
      start = 1'b1; last_addr = 4'd0;
      @(posedge clk); #1;
      load_en = 1'b0; start = 1'b0;
      mprog[0] = {3'd5, 8'h41, 8'h22};
      chk("ls_busy", 32'(busy), 32'd0);
      chk("ls_issue", 32'(issue_valid), 32'd0);
      @(posedge clk); #1;
      chk("ls_busy2", 32'(busy), 32'd0);
      run_check(4'd0, 3, 1'b0);
      rd_addr = 4'd0; #1;
      chk("ls_result", 32'(rd_data), 32'h63);
      // reset during WAIT of instruction index 2 of 4
      for (int i = 0; i < 4; i++) load_word(4'(i), {3'(i), 8'(8'h60 + 8'(i)), 8'h07});
      last_addr = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_pc", 32'(pc), 32'd2);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_issue", 32'(issue_valid), 32'd0);
      #2 rst = 1'b0;
      #1 check_idle_zero("midrst");
      @(posedge clk); #1;
      chk("midrst_busy2", 32'(busy), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) mres[i] = 8'(mprog[i][15:8] + mprog[i][7:0]);
      check_store();
      run_check(4'd3, 9, 1'b0);
      // randomized runs with input noise during execution
      for (int r = 0; r < 8; r++) begin
         logic [3:0] l;
         l = 4'($urandom_range(15));
         for (int i = 0; i <= int'(l); i++) load_word(4'(i), 19'($urandom));
         run_check(l, 2 * (int'(l) + 1) + 1, 1'b1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Feeds the ALU/register datapath. Instruction words (opcode, operand A, operand B) are loaded into an internal program store, then issued one at a time to the datapath.
- After each issue, the sequencer captures the registered datapath output (data_out) into an internal result store.
- It is the driving end of the datapath's opcode/a/b/data_out interface and sits between the test/host loader and the datapath instance.

Parameters:
- ADDR_W, 4, address width of the program and result stores.
- DEPTH, 16, number of entries in each store (2**ADDR_W).
- DATA_W, 8, operand and result width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- load_en  input  1  write load_instr into program store at load_addr; honoured only in IDLE.
- load_addr  input  ADDR_W  program store write address.
- load_instr  input  3+2*DATA_W  instruction word {opcode[18:16], a[15:8], b[7:0]} at defaults.
- start  input  1  begin execution at address 0; honoured only in IDLE.
- last_addr  input  ADDR_W  address of the final instruction; sampled on the accepted start.
- opcode  output  3  opcode to datapath.
- a  output  DATA_W  operand A to datapath.
- b  output  DATA_W  operand B to datapath.
- issue_valid  output  1  high in the ISSUE cycle only.
- result_in  input  DATA_W  datapath registered output (data_out).
- rd_addr  input  ADDR_W  result store read address.
- rd_data  output  DATA_W  result store contents at rd_addr, combinational read.
- pc  output  ADDR_W  current instruction address.
- busy  output  1  high in ISSUE and WAIT.
- done  output  1  one-cycle pulse when the program completes.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; pc=0; opcode=0, a=0, b=0; issue_valid=0; busy=0; done=0; latched last_addr=0.
  - Program and result stores are not reset; their contents are retained across rst.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except rd_data are registered.
- IDLE:
  - load_en=1: the store at load_addr is written at the clock edge.
  - start=1 with load_en=0: latch last_addr, pc<=0, go to ISSUE.
  - load_en=1 and start=1 in the same cycle: the load is performed and start is ignored.
  - opcode/a/b are held at 0.
- ISSUE (1 cycle):
  - opcode/a/b are driven from program store[pc]; issue_valid=1; busy=1.
  - The datapath register captures alu_out at the end of this cycle.
  - Next state: WAIT.
- WAIT (1 cycle):
  - opcode/a/b are held; issue_valid=0; busy=1.
  - At the end of the cycle, result_in is written to result store[pc].
  - If pc==latched last_addr, go to DONE; else pc<=pc+1 and go to ISSUE.
- DONE (1 cycle):
  - done=1; busy=0; opcode/a/b are cleared to 0; pc holds the final address.
  - Next state: IDLE.
- Timing:
  - Throughput is 2 cycles per instruction.
  - For N=last_addr+1 instructions, done asserts 2N+1 cycles after the start edge.
- In all non-IDLE states, load_en and start are ignored and the program store is unchanged.
- pc never wraps: last_addr=DEPTH-1 runs all DEPTH entries and stops. last_addr=0 runs exactly one instruction.
- Changing last_addr mid-run has no effect; only the value latched at start is used.
- rst low mid-run: immediate return to IDLE with all outputs at reset values. Result entries already written are kept; the entry for the interrupted instruction is not written.
- A rd_addr read during a run returns the stored value, including an entry written at the current edge on the following cycle.

Test Plan:
- Bench stub: the datapath is modelled as a registered adder, result_in <= a+b on every clock.
- Load addr0={0,8'h05,8'h03}, last_addr=0, start -> issue_valid pulse with a=8'h05, b=8'h03; done 3 cycles after start; rd_addr=0 gives rd_data=8'h08; busy back to 0.
- Load 4 entries with a=i, b=8'h10 (i=0..3), last_addr=3, start -> four issue_valid pulses spaced 2 cycles; done at cycle 9; rd_data[0..3]=8'h10, 8'h11, 8'h12, 8'h13.
- Assert load_en to addr 0 and start together in IDLE -> store updated, busy stays 0, no issue_valid; start next cycle runs the new word.
- Pulse start and load_en (addr 1, new word) during a run -> no restart, pc sequence unchanged, addr 1 still executes the old word.
- Drop rst during WAIT of instruction 2 of 4 -> outputs zero immediately, state IDLE; rd_data[0] and rd_data[1] still hold their results; a later start reruns from pc=0.
- a=8'hFF, b=8'h01, last_addr=15 with all 16 entries loaded -> result 8'h00 stored (stub wraps modulo 2**DATA_W); pc stops at 15 with no wrap; done at cycle 33.
